// File: rtl/psa_pkg.sv
// Shared PSA definitions: loader FSM encoding, frame header bytes and default BRAM widths.
// Also used by the search engine.
package psa_pkg;

  localparam int PSA_ADDR_W = 8;
  localparam int PSA_DATA_W = 8;

  localparam logic [7:0] PSA_HDR_PAT = 8'hA0;
  localparam logic [7:0] PSA_HDR_BLK = 8'hA1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_CSUM  = 3'd5,
    ST_FIN   = 3'd6
  } loader_state_t;

endpackage

// File: rtl/psa_bram_loader_if.sv
// Bundle of the loader's byte stream, both BRAM write ports and the published frame results.
// Stream handshake: a byte moves on a clock edge where s_valid && s_ready; s_data is held while s_valid waits.
interface psa_bram_loader_if
  import psa_pkg::*;
#(
  parameter int ADDR_W = PSA_ADDR_W,
  parameter int DATA_W = PSA_DATA_W
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              pat_we;
  logic [ADDR_W-1:0] pat_addr;
  logic [DATA_W-1:0] pat_din;
  logic              blk_we;
  logic [ADDR_W-1:0] blk_addr;
  logic [DATA_W-1:0] blk_din;
  logic [ADDR_W-1:0] p;
  logic [ADDR_W-1:0] pl;
  logic [ADDR_W-1:0] b;
  logic [ADDR_W-1:0] bl;
  logic              busy;
  logic              load_done;
  logic              err;
  loader_state_t     state;

  modport master (
    output s_data, s_valid,
    input  s_ready, pat_we, pat_addr, pat_din, blk_we, blk_addr, blk_din,
    input  p, pl, b, bl, busy, load_done, err, state
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, pat_we, pat_addr, pat_din, blk_we, blk_addr, blk_din,
    output p, pl, b, bl, busy, load_done, err, state
  );
endinterface

// File: rtl/psa_bram_wport.sv
// Registered BRAM write-port driver: we/addr/din appear one cycle after the request.
module psa_bram_wport #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] din_o
);

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;

  // addr/din only move on a write so the BRAM pins stay quiet between bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
    end else begin
      we_q <= we_i;
      if (we_i) begin
        addr_q <= addr_i;
        din_q  <= din_i;
      end
    end
  end

  assign we_o   = we_q;
  assign addr_o = addr_q;
  assign din_o  = din_q;

endmodule

// File: rtl/psa_bram_loader.sv
// Framed byte stream -> pattern/block BRAM writer; publishes start/length of the last good frame.
// Optional trailing XOR checksum byte when PSA_LOADER_CHECKSUM_EN is defined.
module psa_bram_loader
  import psa_pkg::*;
#(
  parameter int          ADDR_W  = PSA_ADDR_W,
  parameter int          DATA_W  = PSA_DATA_W,
  parameter logic [7:0]  HDR_PAT = PSA_HDR_PAT,
  parameter logic [7:0]  HDR_BLK = PSA_HDR_BLK
) (
  input  logic             CLK100MHZ,
  input  logic             reset,
  psa_bram_loader_if.slave ldr
);

`ifdef PSA_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam loader_state_t TAIL_ST = CSUM_EN ? ST_CSUM : ST_FIN;
  localparam logic [ADDR_W:0] SPACE = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t     state_q, state_d;
  logic              tgt_blk_q, tgt_blk_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] csum_q, csum_d;
  logic [ADDR_W-1:0] p_q, p_d, pl_q, pl_d, b_q, b_d, bl_q, bl_d;

  logic              accept;
  logic              wr_en;
  logic [ADDR_W-1:0] byte_a;
  logic [ADDR_W:0]   end_sum;

  assign ldr.s_ready = (state_q != ST_FIN);
  assign accept      = ldr.s_valid && ldr.s_ready;
  assign byte_a      = ADDR_W'(ldr.s_data);
  assign end_sum     = {1'b0, start_q} + {1'b0, byte_a};
  assign wr_en       = (state_q == ST_DATA) && accept;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tgt_blk_q <= 1'b0;
      start_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      csum_q    <= '0;
      p_q       <= '0;
      pl_q      <= '0;
      b_q       <= '0;
      bl_q      <= '0;
    end else begin
      state_q   <= state_d;
      tgt_blk_q <= tgt_blk_d;
      start_q   <= start_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      csum_q    <= csum_d;
      p_q       <= p_d;
      pl_q      <= pl_d;
      b_q       <= b_d;
      bl_q      <= bl_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_blk_d = tgt_blk_q;
    start_d   = start_q;
    len_d     = len_q;
    idx_d     = idx_q;
    err_d     = err_q;
    busy_d    = busy_q;
    csum_d    = csum_q;
    p_d       = p_q;
    pl_d      = pl_q;
    b_d       = b_q;
    bl_d      = bl_q;
    unique case (state_q)
      ST_IDLE: begin
        // Non-header bytes are line noise between frames and are dropped silently.
        if (accept && (ldr.s_data == HDR_PAT || ldr.s_data == HDR_BLK)) begin
          tgt_blk_d = (ldr.s_data == HDR_BLK);
          err_d     = 1'b0;
          busy_d    = 1'b1;
          csum_d    = ldr.s_data;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (accept) begin
          start_d = byte_a;
          csum_d  = csum_q ^ ldr.s_data;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          len_d  = byte_a;
          idx_d  = '0;
          csum_d = csum_q ^ ldr.s_data;
          if (end_sum > SPACE) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else if (byte_a == '0) begin
            state_d = TAIL_ST;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA, ST_DRAIN: begin
        if (accept) begin
          idx_d  = idx_q + ADDR_W'(1);
          csum_d = csum_q ^ ldr.s_data;
          if (idx_q == len_q - ADDR_W'(1)) state_d = TAIL_ST;
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (ldr.s_data != csum_q) err_d = 1'b1;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (!err_q) begin
          if (tgt_blk_q) begin
            b_d  = start_q;
            bl_d = len_q;
          end else begin
            p_d  = start_q;
            pl_d = len_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  psa_bram_wport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pat_port (
    .clk(CLK100MHZ), .rst(reset),
    .we_i(wr_en && !tgt_blk_q), .addr_i(start_q + idx_q), .din_i(ldr.s_data),
    .we_o(ldr.pat_we), .addr_o(ldr.pat_addr), .din_o(ldr.pat_din)
  );

  psa_bram_wport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_blk_port (
    .clk(CLK100MHZ), .rst(reset),
    .we_i(wr_en && tgt_blk_q), .addr_i(start_q + idx_q), .din_i(ldr.s_data),
    .we_o(ldr.blk_we), .addr_o(ldr.blk_addr), .din_o(ldr.blk_din)
  );

  assign ldr.p         = p_q;
  assign ldr.pl        = pl_q;
  assign ldr.b         = b_q;
  assign ldr.bl        = bl_q;
  assign ldr.busy      = busy_q;
  assign ldr.load_done = (state_q == ST_FIN) && !err_q;
  assign ldr.err       = (state_q == ST_FIN) && err_q;
  assign ldr.state     = state_q;

endmodule

// File: tb/tb_psa_bram_loader.sv
// Directed table-driven bench for psa_bram_loader plus hand sequences for FIN, checksum and reset.
module tb_psa_bram_loader;
  import psa_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psa_bram_loader_if bus ();
  psa_bram_loader dut (.CLK100MHZ(clk), .reset(rst), .ldr(bus));

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [16:0] exp_q[$];     // {is_blk, addr, data}
  logic [7:0]  stream_q[$];

  typedef struct {
    bit         has_junk;
    logic [7:0] junk;
    logic [7:0] hdr, addr, len, base;
    bit         toggle;
    bit         good;
    logic [7:0] p, pl, b, bl;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic log_write(input logic [16:0] w);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_write: got %0h expected none", w);
    end else begin
      logic [16:0] e;
      e = exp_q.pop_front();
      if (w !== e) begin
        failures++;
        $display("FAIL bram_write: got %0h expected %0h", w, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.pat_we) log_write({1'b0, bus.pat_addr, bus.pat_din});
    if (bus.blk_we) log_write({1'b1, bus.blk_addr, bus.blk_din});
    if (bus.load_done) done_cnt++;
    if (bus.err) err_cnt++;
  end

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bit taken;
    taken = 1'b0;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      @(negedge clk);
      if (bus.s_ready) taken = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!taken) check("accept_timeout", 32'd0, 32'd1);
    bus.s_valid = 1'b0;
  endtask

  task automatic send_stream(input bit toggle);
    while (stream_q.size() > 0) begin
      send_byte(stream_q.pop_front());
      if (toggle && stream_q.size() > 0) idle(1);
    end
  endtask

  // Frame bytes in order; the trailing XOR byte only exists in checksum builds.
  task automatic build_frame(input logic [7:0] hdr, input logic [7:0] addr,
                             input logic [7:0] len, input logic [7:0] base);
    logic [7:0] x;
    stream_q.push_back(hdr);
    stream_q.push_back(addr);
    stream_q.push_back(len);
    x = hdr ^ addr ^ len;
    for (int i = 0; i < int'(len); i++) begin
      stream_q.push_back(base + 8'(i));
      x = x ^ (base + 8'(i));
    end
`ifdef PSA_LOADER_CHECKSUM_EN
    stream_q.push_back(x);
`endif
  endtask

  task automatic expect_writes(input logic is_blk, input logic [7:0] addr,
                               input logic [7:0] len, input logic [7:0] base);
    for (int i = 0; i < int'(len); i++) exp_q.push_back({is_blk, addr + 8'(i), base + 8'(i)});
  endtask

  task automatic check_results(input string tag, input logic [7:0] p, input logic [7:0] pl,
                               input logic [7:0] b, input logic [7:0] bl);
    check({tag, "_p"}, 32'(bus.p), 32'(p));
    check({tag, "_pl"}, 32'(bus.pl), 32'(pl));
    check({tag, "_b"}, 32'(bus.b), 32'(b));
    check({tag, "_bl"}, 32'(bus.bl), 32'(bl));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int d0, e0;
    vecs[0] = '{1'b0, 8'h00, 8'hA0, 8'h02, 8'h02, 8'h61, 1'b0, 1'b1, 8'h02, 8'h02, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 8'h00, 8'hA1, 8'h00, 8'h14, 8'h10, 1'b1, 1'b1, 8'h02, 8'h02, 8'h00, 8'h14};
    vecs[2] = '{1'b0, 8'h00, 8'hA1, 8'hF0, 8'h20, 8'h80, 1'b0, 1'b0, 8'h02, 8'h02, 8'h00, 8'h14};
    vecs[3] = '{1'b1, 8'h55, 8'hA0, 8'h05, 8'h00, 8'h00, 1'b0, 1'b1, 8'h05, 8'h00, 8'h00, 8'h14};
    vecs[4] = '{1'b0, 8'h00, 8'hA1, 8'hF0, 8'h10, 8'h40, 1'b0, 1'b1, 8'h05, 8'h00, 8'hF0, 8'h10};
    vecs[5] = '{1'b0, 8'h00, 8'hA0, 8'hFF, 8'h02, 8'h90, 1'b1, 1'b0, 8'h05, 8'h00, 8'hF0, 8'h10};

    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst_ready", 32'(bus.s_ready), 32'd1);
    check("rst_outs", {bus.pat_we, bus.blk_we, bus.busy, bus.load_done, bus.err}, 32'd0);
    check_results("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      if (vecs[v].has_junk) stream_q.push_back(vecs[v].junk);
      build_frame(vecs[v].hdr, vecs[v].addr, vecs[v].len, vecs[v].base);
      if (vecs[v].good) expect_writes(vecs[v].hdr == 8'hA1, vecs[v].addr, vecs[v].len, vecs[v].base);
      send_stream(vecs[v].toggle);
      idle(3);
      check($sformatf("v%0d_done", v), 32'(done_cnt - d0), vecs[v].good ? 32'd1 : 32'd0);
      check($sformatf("v%0d_err", v), 32'(err_cnt - e0), vecs[v].good ? 32'd0 : 32'd1);
      check_results($sformatf("v%0d", v), vecs[v].p, vecs[v].pl, vecs[v].b, vecs[v].bl);
    end

    // FIN cycle: s_ready low with the done pulse, then a held byte goes through next cycle.
    build_frame(8'hA0, 8'h20, 8'h01, 8'h7A);
    expect_writes(1'b0, 8'h20, 8'h01, 8'h7A);
    send_stream(1'b0);
    check("fin_ready", 32'(bus.s_ready), 32'd0);
    check("fin_done", 32'(bus.load_done), 32'd1);
    check("fin_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h33);
    check("fin_held_byte_taken", 32'(bus.state), 32'(ST_IDLE));
    check("fin_done_one_cycle", 32'(bus.load_done), 32'd0);
    idle(2);
    check_results("fin", 8'h20, 8'h01, 8'hF0, 8'h10);

`ifdef PSA_LOADER_CHECKSUM_EN
    d0 = done_cnt;
    stream_q = '{8'hA0, 8'h00, 8'h01, 8'h33, 8'h92};
    exp_q.push_back({1'b0, 8'h00, 8'h33});
    send_stream(1'b0);
    idle(3);
    check("csum_good_done", 32'(done_cnt - d0), 32'd1);
    check_results("csum_good", 8'h00, 8'h01, 8'hF0, 8'h10);
    e0 = err_cnt;
    stream_q = '{8'hA0, 8'h07, 8'h01, 8'h33, 8'h00};
    exp_q.push_back({1'b0, 8'h07, 8'h33});
    send_stream(1'b0);
    idle(3);
    check("csum_bad_err", 32'(err_cnt - e0), 32'd1);
    check_results("csum_bad", 8'h00, 8'h01, 8'hF0, 8'h10);
`endif

    // Reset in the middle of a 10-byte frame, after its 3rd payload byte.
    stream_q = '{8'hA0, 8'h10, 8'h0A, 8'hC0, 8'hC1, 8'hC2};
    expect_writes(1'b0, 8'h10, 8'h03, 8'hC0);
    send_stream(1'b0);
    check("midrst_busy", 32'(bus.busy), 32'd1);
    idle(1);
    rst = 1'b1;
    #1;
    check("midrst_outs", {bus.pat_we, bus.blk_we, bus.busy, bus.load_done, bus.err}, 32'd0);
    check_results("midrst", 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 7; i++) stream_q.push_back(8'(i + 1));
    send_stream(1'b0);
    idle(3);
    check("postrst_tail_ignored", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    build_frame(8'hA1, 8'h03, 8'h02, 8'h77);
    expect_writes(1'b1, 8'h03, 8'h02, 8'h77);
    send_stream(1'b0);
    idle(3);
    check("postrst_done", 32'(done_cnt - d0), 32'd1);
    check_results("postrst", 8'h00, 8'h00, 8'h03, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
